// File: rtl/sistema_pio_arb_pkg.sv
// Shared types and constants for the two-master PIO arbiter.
// Optional grant statistics are enabled with the SISTEMA_PIO_ARB_STATS_EN macro.
package sistema_pio_arb_pkg;

    localparam int CNT_W      = 16;
    localparam int DEF_ADDR_W = 2;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/sistema_pio_arb_sat_cnt.sv
// 16-bit counter with enable that sticks at all-ones instead of wrapping.
module sistema_pio_arb_sat_cnt
    import sistema_pio_arb_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    // Count enabled cycles; hold once the maximum value is reached.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (en && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sistema_pio_arbiter.sv
// Round-robin arbiter letting two bus masters share one PIO slave.
// Each grant lasts one cycle; a tie goes to the master not served last.
// Define SISTEMA_PIO_ARB_STATS_EN to build the per-master grant counters;
// without it grant_cnt0/grant_cnt1 read as zero.
module sistema_pio_arbiter
    import sistema_pio_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_chipselect,
    input  logic              m0_write_n,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_waitrequest,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_chipselect,
    input  logic              m1_write_n,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_waitrequest,

    output logic [ADDR_W-1:0] s_address,
    output logic              s_chipselect,
    output logic              s_write_n,
    output logic [DATA_W-1:0] s_writedata,
    input  logic [DATA_W-1:0] s_readdata,

    output logic [CNT_W-1:0]  grant_cnt0,
    output logic [CNT_W-1:0]  grant_cnt1
);

    // Handshake: a master asserts chipselect and holds all of its inputs while
    // waitrequest is high; the transfer completes in the cycle waitrequest is
    // low with chipselect high (the GRANT cycle of that master).

    arb_state_t state;
    arb_state_t next_state;
    logic       last_grant;
    logic       next_last_grant;

    // State and fairness bookkeeping; reset forces IDLE so the slave bus drops at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state      <= next_state;
            last_grant <= next_last_grant;
        end
    end

    // Next grant: the served master's own request is ignored so the other gets a turn.
    always_comb begin
        next_state      = IDLE;
        next_last_grant = last_grant;
        case (state)
            IDLE: begin
                if (m0_chipselect && m1_chipselect) begin
                    next_state = last_grant ? GRANT0 : GRANT1;
                end else if (m0_chipselect) begin
                    next_state = GRANT0;
                end else if (m1_chipselect) begin
                    next_state = GRANT1;
                end
            end
            GRANT0: begin
                next_last_grant = 1'b0;
                next_state      = m1_chipselect ? GRANT1 : IDLE;
            end
            GRANT1: begin
                next_last_grant = 1'b1;
                next_state      = m0_chipselect ? GRANT0 : IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Slave bus mux and read-data return, driven only from the state register.
    always_comb begin
        s_address    = '0;
        s_chipselect = 1'b0;
        s_write_n    = 1'b1;
        s_writedata  = '0;
        m0_readdata  = '0;
        m1_readdata  = '0;
        case (state)
            GRANT0: begin
                s_address    = m0_address;
                s_chipselect = m0_chipselect;
                s_write_n    = m0_write_n;
                s_writedata  = m0_writedata;
                m0_readdata  = s_readdata;
            end
            GRANT1: begin
                s_address    = m1_address;
                s_chipselect = m1_chipselect;
                s_write_n    = m1_write_n;
                s_writedata  = m1_writedata;
                m1_readdata  = s_readdata;
            end
            default: begin
                s_chipselect = 1'b0;
            end
        endcase
    end

    assign m0_waitrequest = m0_chipselect && (state != GRANT0);
    assign m1_waitrequest = m1_chipselect && (state != GRANT1);

`ifdef SISTEMA_PIO_ARB_STATS_EN
    logic cnt0_en;
    logic cnt1_en;

    // A grant only counts when the master still holds chipselect.
    assign cnt0_en = (state == GRANT0) && m0_chipselect;
    assign cnt1_en = (state == GRANT1) && m1_chipselect;

    sistema_pio_arb_sat_cnt u_cnt0 (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (cnt0_en),
        .count   (grant_cnt0)
    );

    sistema_pio_arb_sat_cnt u_cnt1 (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (cnt1_en),
        .count   (grant_cnt1)
    );
`else
    assign grant_cnt0 = '0;
    assign grant_cnt1 = '0;
`endif

endmodule

// File: tb/tb_sistema_pio_arbiter.sv
// Bench for sistema_pio_arbiter: directed master transfers, a small PIO slave
// model, and a scoreboard of expected slave accesses checked by a monitor.
// Honours SISTEMA_PIO_ARB_STATS_EN for the grant counter expectations.
module tb_sistema_pio_arbiter;

    localparam int AW = 2;
    localparam int DW = 32;
    localparam int W  = 84;  // {master, write_n, addr, wdata, rdata, cycle[15:0]}

`ifdef SISTEMA_PIO_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk;
    logic          reset_n;
    logic [AW-1:0] m0_address, m1_address, s_address;
    logic          m0_chipselect, m1_chipselect, s_chipselect;
    logic          m0_write_n, m1_write_n, s_write_n;
    logic [DW-1:0] m0_writedata, m1_writedata, s_writedata;
    logic [DW-1:0] m0_readdata, m1_readdata, s_readdata;
    logic          m0_waitrequest, m1_waitrequest;
    logic [15:0]   grant_cnt0, grant_cnt1;

    logic [W-1:0]  exp_q[$];
    int            n_vec = 0;
    int            n_err = 0;
    int            cyc   = 0;
    logic [1:0]    pio;

    sistema_pio_arbiter dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .m0_address     (m0_address),
        .m0_chipselect  (m0_chipselect),
        .m0_write_n     (m0_write_n),
        .m0_writedata   (m0_writedata),
        .m0_readdata    (m0_readdata),
        .m0_waitrequest (m0_waitrequest),
        .m1_address     (m1_address),
        .m1_chipselect  (m1_chipselect),
        .m1_write_n     (m1_write_n),
        .m1_writedata   (m1_writedata),
        .m1_readdata    (m1_readdata),
        .m1_waitrequest (m1_waitrequest),
        .s_address      (s_address),
        .s_chipselect   (s_chipselect),
        .s_write_n      (s_write_n),
        .s_writedata    (s_writedata),
        .s_readdata     (s_readdata),
        .grant_cnt0     (grant_cnt0),
        .grant_cnt1     (grant_cnt1)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // PIO slave model: address 0 holds a 2-bit output register.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) pio <= 2'b00;
        else if (s_chipselect && !s_write_n && s_address == 2'd0) pio <= s_writedata[1:0];
    end
    assign s_readdata = {30'b0, pio};

    // ---------------- scoreboard helpers ----------------
    function automatic logic [W-1:0] mk(input logic mst, input logic wn, input logic [1:0] a,
                                        input logic [31:0] d, input logic [31:0] rd, input int c);
        return {mst, wn, a, d, rd, c[15:0]};
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic mst, input logic wn, input logic [1:0] a,
                        input logic [31:0] d, input logic [31:0] rd, input int c);
        exp_q.push_back(mk(mst, wn, a, d, rd, c));
    endtask

    // ---------------- monitor ----------------
    logic         mon_mst;
    logic [31:0]  mon_rd, mon_other;
    logic [W-1:0] mon_e;

    always @(negedge clk) begin
        if (s_chipselect === 1'b1) begin
            mon_mst   = (m0_chipselect && !m0_waitrequest) ? 1'b0 : 1'b1;
            mon_rd    = mon_mst ? m1_readdata : m0_readdata;
            mon_other = mon_mst ? m0_readdata : m1_readdata;
            if (exp_q.size() == 0) begin
                check("unexpected_access", mk(mon_mst, s_write_n, s_address, s_writedata, mon_rd, cyc), '0);
            end else begin
                mon_e = exp_q.pop_front();
                check("access", mk(mon_mst, s_write_n, s_address, s_writedata, mon_rd, cyc), mon_e);
                check("other_rdata", W'(mon_other), W'(0));
            end
        end else begin
            check("idle_bus", W'({s_write_n, s_address, s_writedata, m0_readdata, m1_readdata}),
                  W'({1'b1, 2'b00, 32'h0, 32'h0, 32'h0}));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic xfer(input logic mst, input logic wn, input logic [1:0] a, input logic [31:0] d);
        int n = 0;
        if (!mst) begin
            m0_address = a; m0_write_n = wn; m0_writedata = d; m0_chipselect = 1'b1;
        end else begin
            m1_address = a; m1_write_n = wn; m1_writedata = d; m1_chipselect = 1'b1;
        end
        @(negedge clk);
        while ((mst ? m1_waitrequest : m0_waitrequest) && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("grant_within_bound", W'(n < 10), W'(1));
        @(posedge clk); #1;
        if (!mst) m0_chipselect = 1'b0;
        else      m1_chipselect = 1'b0;
    endtask

    task automatic reset_pulse();
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        reset_n       = 1'b0;
        m0_address    = '0; m0_chipselect = 1'b1; m0_write_n = 1'b1; m0_writedata = '0;
        m1_address    = '0; m1_chipselect = 1'b0; m1_write_n = 1'b1; m1_writedata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_s_cs", W'(s_chipselect), W'(0));
        check("rst_m0_wait", W'(m0_waitrequest), W'(1));
        check("rst_m1_wait", W'(m1_waitrequest), W'(0));
        check("rst_cnts", W'({grant_cnt0, grant_cnt1}), W'(0));
        m0_chipselect = 1'b0;
        reset_n       = 1'b1;
        @(posedge clk); #1;

        // Single m0 write: one wait cycle, access in the next cycle.
        push(1'b0, 1'b0, 2'd0, 32'h3, 32'h0, cyc + 1);
        fork
            xfer(1'b0, 1'b0, 2'd0, 32'h3);
            begin @(negedge clk); check("t1_wait_first", W'(m0_waitrequest), W'(1)); end
        join
        check("t1_pio", W'(pio), W'(2'b11));

        // Simultaneous writes after reset: m0 first, m1 one cycle later.
        reset_pulse();
        push(1'b0, 1'b0, 2'd0, 32'h1, 32'h0, cyc + 1);
        push(1'b1, 1'b0, 2'd0, 32'h2, 32'h1, cyc + 2);
        fork
            xfer(1'b0, 1'b0, 2'd0, 32'h1);
            xfer(1'b1, 1'b0, 2'd0, 32'h2);
        join
        check("t2_pio", W'(pio), W'(2'b10));

        // Both masters reading continuously: strict alternation starting with m0.
        m0_address = 2'd1; m0_write_n = 1'b1; m0_writedata = 32'hA5A5_0000;
        m1_address = 2'd2; m1_write_n = 1'b1; m1_writedata = 32'h5A5A_0001;
        for (int k = 1; k <= 8; k++) begin
            if (k % 2 == 1) push(1'b0, 1'b1, 2'd1, 32'hA5A5_0000, 32'h2, cyc + k);
            else            push(1'b1, 1'b1, 2'd2, 32'h5A5A_0001, 32'h2, cyc + k);
        end
        m0_chipselect = 1'b1;
        m1_chipselect = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        m0_chipselect = 1'b0;
        @(posedge clk); #1;
        m1_chipselect = 1'b0;
        @(posedge clk); #1;

        // m1 reads the PIO value 2.
        push(1'b1, 1'b1, 2'd0, 32'h7, 32'h2, cyc + 1);
        xfer(1'b1, 1'b1, 2'd0, 32'h7);

        // Reset during GRANT1 aborts the access immediately.
        m1_address = 2'd0; m1_write_n = 1'b0; m1_writedata = 32'h1; m1_chipselect = 1'b1;
        @(posedge clk); #1;
        check("t5_granted", W'(m1_waitrequest), W'(0));
        reset_n = 1'b0;
        #1;
        check("t5_async_cs", W'(s_chipselect), W'(0));
        check("t5_wait_idle", W'(m1_waitrequest), W'(1));
        m1_chipselect = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("t5_pio", W'(pio), W'(2'b00));
        push(1'b0, 1'b1, 2'd0, 32'h11, 32'h0, cyc + 1);
        push(1'b1, 1'b1, 2'd0, 32'h22, 32'h0, cyc + 2);
        fork
            xfer(1'b0, 1'b1, 2'd0, 32'h11);
            xfer(1'b1, 1'b1, 2'd0, 32'h22);
        join

        // Complete 3 m0 and 2 m1 transfers since the last reset.
        push(1'b0, 1'b0, 2'd0, 32'h3, 32'h0, cyc + 1);
        xfer(1'b0, 1'b0, 2'd0, 32'h3);
        push(1'b0, 1'b0, 2'd0, 32'h1, 32'h3, cyc + 1);
        xfer(1'b0, 1'b0, 2'd0, 32'h1);
        push(1'b1, 1'b0, 2'd0, 32'h2, 32'h1, cyc + 1);
        xfer(1'b1, 1'b0, 2'd0, 32'h2);
        check("cnt0", W'(grant_cnt0), STATS ? W'(3) : W'(0));
        check("cnt1", W'(grant_cnt1), STATS ? W'(2) : W'(0));

`ifdef SISTEMA_PIO_ARB_STATS_EN
        // Saturation: preload the m0 counter at its maximum, then grant once more.
        force dut.u_cnt0.count = 16'hFFFF;
        @(negedge clk);
        release dut.u_cnt0.count;
        @(posedge clk); #1;
        push(1'b0, 1'b0, 2'd0, 32'h3, 32'h2, cyc + 1);
        xfer(1'b0, 1'b0, 2'd0, 32'h3);
        check("cnt0_sat", W'(grant_cnt0), W'(16'hFFFF));
`endif

        @(posedge clk); #1;
        check("queue_empty", W'(exp_q.size()), W'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
